// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-side hazard scoreboard.
package hazard_pkg;

   localparam int FWD_RF      = 0;
   localparam int SB_RD_MAX_W = 8;

   typedef struct packed {
      logic                   valid;
      logic [SB_RD_MAX_W-1:0] rd;
      logic                   is_load;
   } sb_entry_t;

   function automatic int fsel_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/md_sequencer.sv
// Busy counter for the single iterative mul/div unit: issue gating, busy flag
// and a registered done pulse on the last busy cycle.
module md_sequencer
   import hazard_pkg::*;
#(
   parameter int MD_LATENCY = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic start_req,
   input  logic issue_block,
   output logic md_issue,
   output logic md_busy,
   output logic md_done
);

   localparam int               CNT_W    = $clog2(MD_LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_next_s;
   logic             done_r;

   assign md_busy  = (cnt_r != {CNT_W{1'b0}});
   assign md_issue = start_req & ~md_busy & ~issue_block;
   assign md_done  = done_r;

   // Next counter value: load on issue, count down while busy.
   always_comb begin
      cnt_next_s = cnt_r;
      if (md_issue) begin
         cnt_next_s = CNT_LOAD;
      end else if (md_busy) begin
         cnt_next_s = cnt_r - CNT_W'(1);
      end else begin
         cnt_next_s = cnt_r;
      end
   end

   // Counter and done pulse; done fires in the cycle the counter reads 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r  <= {CNT_W{1'b0}};
         done_r <= 1'b0;
      end else begin
         cnt_r  <= cnt_next_s;
         done_r <= (cnt_next_s == CNT_W'(1));
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard scoreboard: forwarding selects, load-use/branch/mul-div stalls.
// Optional stall-cycle counter port enabled by defining HAZARD_PERF_CNT_EN.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter  int REG_ADDR_W = 5,
   parameter  int FWD_DEPTH  = 3,
   parameter  int MD_LATENCY = 32,
   localparam int FSEL_W     = fsel_w(FWD_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  dec_valid,
   input  logic [REG_ADDR_W-1:0] dec_rs,
   input  logic [REG_ADDR_W-1:0] dec_rt,
   input  logic [REG_ADDR_W-1:0] dec_rd,
   input  logic                  dec_regwrite,
   input  logic                  dec_is_load,
   input  logic                  dec_is_branch,
   input  logic                  dec_md_start,
   input  logic                  dec_md_read,
   input  logic                  flush_decode,
   output logic                  stall_pc,
   output logic                  stall_decode,
   output logic                  flush_exe,
   output logic [FSEL_W-1:0]     fwd_a,
   output logic [FSEL_W-1:0]     fwd_b,
   output logic                  md_issue,
   output logic                  md_busy,
   output logic                  md_done
`ifdef HAZARD_PERF_CNT_EN
  ,output logic [31:0]           perf_stall_cycles
`endif
);

   sb_entry_t              sb_r [FWD_DEPTH];
   sb_entry_t              new_entry_s;
   logic [SB_RD_MAX_W-1:0] rs_ext_s;
   logic [SB_RD_MAX_W-1:0] rt_ext_s;
   logic [SB_RD_MAX_W-1:0] rd_ext_s;
   logic [FSEL_W-1:0]      fwd_a_s;
   logic [FSEL_W-1:0]      fwd_b_s;
   logic                   load_use_s;
   logic                   branch_haz_s;
   logic                   md_haz_s;
   logic                   stall_s;
   logic                   md_busy_s;

   // Widen register addresses to the entry's fixed rd width.
   always_comb begin
      rs_ext_s = {SB_RD_MAX_W{1'b0}};
      rt_ext_s = {SB_RD_MAX_W{1'b0}};
      rd_ext_s = {SB_RD_MAX_W{1'b0}};
      rs_ext_s[REG_ADDR_W-1:0] = dec_rs;
      rt_ext_s[REG_ADDR_W-1:0] = dec_rt;
      rd_ext_s[REG_ADDR_W-1:0] = dec_rd;
   end

   // Youngest matching producer wins; a load still in EXE has no data yet.
   always_comb begin
      fwd_a_s = FSEL_W'(FWD_RF);
      fwd_b_s = FSEL_W'(FWD_RF);
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
         fwd_a_s = (sb_r[k].valid && !(k == 0 && sb_r[0].is_load) && (sb_r[k].rd == rs_ext_s))
                   ? FSEL_W'(k + 1) : fwd_a_s;
         fwd_b_s = (sb_r[k].valid && !(k == 0 && sb_r[0].is_load) && (sb_r[k].rd == rt_ext_s))
                   ? FSEL_W'(k + 1) : fwd_b_s;
      end
      fwd_a_s = (dec_rs == {REG_ADDR_W{1'b0}}) ? FSEL_W'(FWD_RF) : fwd_a_s;
      fwd_b_s = (dec_rt == {REG_ADDR_W{1'b0}}) ? FSEL_W'(FWD_RF) : fwd_b_s;
   end

   assign load_use_s = dec_valid & sb_r[0].valid & sb_r[0].is_load &
                       (((dec_rs != {REG_ADDR_W{1'b0}}) & (sb_r[0].rd == rs_ext_s)) |
                        ((dec_rt != {REG_ADDR_W{1'b0}}) & (sb_r[0].rd == rt_ext_s)));

   // Branches compare in decode, so an EXE result or a load in MEM is too late.
   assign branch_haz_s = dec_is_branch &
                         ((sb_r[0].valid & ((sb_r[0].rd == rs_ext_s) | (sb_r[0].rd == rt_ext_s))) |
                          (sb_r[1].valid & sb_r[1].is_load &
                           ((sb_r[1].rd == rs_ext_s) | (sb_r[1].rd == rt_ext_s))));

   assign md_haz_s = dec_valid & (dec_md_start | dec_md_read) & md_busy_s;
   assign stall_s  = load_use_s | branch_haz_s | md_haz_s;

   assign new_entry_s.valid   = dec_valid & dec_regwrite & (dec_rd != {REG_ADDR_W{1'b0}}) &
                                ~stall_s & ~flush_decode;
   assign new_entry_s.rd      = rd_ext_s;
   assign new_entry_s.is_load = dec_is_load;

   // Scoreboard shift; stalls and flushes enter as bubbles at the head.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FWD_DEPTH; i++) begin
            sb_r[i] <= '0;
         end
      end else begin
         sb_r[0] <= new_entry_s;
         for (int i = 1; i < FWD_DEPTH; i++) begin
            sb_r[i] <= sb_r[i-1];
         end
      end
   end

   md_sequencer #(
      .MD_LATENCY (MD_LATENCY)
   ) u_md_sequencer (
      .clk         (clk),
      .rst         (rst),
      .start_req   (dec_valid & dec_md_start),
      .issue_block (load_use_s | branch_haz_s | flush_decode),
      .md_issue    (md_issue),
      .md_busy     (md_busy_s),
      .md_done     (md_done)
   );

   assign md_busy      = md_busy_s;
   assign stall_pc     = stall_s;
   assign stall_decode = stall_s;
   assign flush_exe    = stall_s | flush_decode;
   assign fwd_a        = fwd_a_s;
   assign fwd_b        = fwd_b_s;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_r;

   // Saturating count of stalled cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_r <= 32'd0;
      end else if (stall_s && (perf_r != 32'hFFFF_FFFF)) begin
         perf_r <= perf_r + 32'd1;
      end else begin
         perf_r <= perf_r;
      end
   end

   assign perf_stall_cycles = perf_r;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios then random
// decode traffic, all checked against a queue/cycle-arithmetic reference model.
module tb_hazard_scoreboard;

   localparam int D   = 3;
   localparam int LAT = 4;
   localparam int RW  = 5;
   localparam int FW  = 2;

   logic          clk;
   logic          rst;
   logic          dec_valid;
   logic [RW-1:0] dec_rs;
   logic [RW-1:0] dec_rt;
   logic [RW-1:0] dec_rd;
   logic          dec_regwrite;
   logic          dec_is_load;
   logic          dec_is_branch;
   logic          dec_md_start;
   logic          dec_md_read;
   logic          flush_decode;
   logic          stall_pc;
   logic          stall_decode;
   logic          flush_exe;
   logic [FW-1:0] fwd_a;
   logic [FW-1:0] fwd_b;
   logic          md_issue;
   logic          md_busy;
   logic          md_done;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0]   perf_stall_cycles;
`endif

   hazard_scoreboard #(
      .REG_ADDR_W (RW),
      .FWD_DEPTH  (D),
      .MD_LATENCY (LAT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .dec_valid     (dec_valid),
      .dec_rs        (dec_rs),
      .dec_rt        (dec_rt),
      .dec_rd        (dec_rd),
      .dec_regwrite  (dec_regwrite),
      .dec_is_load   (dec_is_load),
      .dec_is_branch (dec_is_branch),
      .dec_md_start  (dec_md_start),
      .dec_md_read   (dec_md_read),
      .flush_decode  (flush_decode),
      .stall_pc      (stall_pc),
      .stall_decode  (stall_decode),
      .flush_exe     (flush_exe),
      .fwd_a         (fwd_a),
      .fwd_b         (fwd_b),
      .md_issue      (md_issue),
      .md_busy       (md_busy),
      .md_done       (md_done)
`ifdef HAZARD_PERF_CNT_EN
     ,.perf_stall_cycles (perf_stall_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit valid;
      int rd;
      bit ld;
   } wr_t;

   wr_t hist[$];          // hist[a]: instruction that left decode a+1 cycles ago
   int  cyc     = 0;
   int  iss     = -1000;  // cycle of the most recent mul/div issue
   int  perf_m  = 0;
   int  checks  = 0;
   int  errors  = 0;
   bit  chk_en  = 1'b0;

   int  e_fa, e_fb;
   bit  e_stall, e_flush, e_issue, e_busy, e_done;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int fwd_of(input int src);
      if (src == 0) return 0;
      for (int a = 0; a < D; a++)
         if (hist[a].valid && hist[a].rd == src && !(a == 0 && hist[a].ld)) return a + 1;
      return 0;
   endfunction

   task automatic model_reset();
      wr_t e;
      e.valid = 1'b0; e.rd = 0; e.ld = 1'b0;
      hist.delete();
      for (int i = 0; i < D; i++) hist.push_back(e);
      iss    = -1000;
      perf_m = 0;
   endtask

   task automatic drive(input int v, input int rs, input int rt, input int rd, input int rw,
                        input int ld, input int br, input int ms, input int mr, input int fl,
                        input int r);
      bit lu, bh, mh;
      dec_valid     = (v != 0);
      dec_rs        = RW'(rs);
      dec_rt        = RW'(rt);
      dec_rd        = RW'(rd);
      dec_regwrite  = (rw != 0);
      dec_is_load   = (ld != 0);
      dec_is_branch = (br != 0);
      dec_md_start  = (ms != 0);
      dec_md_read   = (mr != 0);
      flush_decode  = (fl != 0);
      rst           = (r != 0);
      #2;
      lu = dec_valid && hist[0].valid && hist[0].ld &&
           ((rs != 0 && rs == hist[0].rd) || (rt != 0 && rt == hist[0].rd));
      bh = dec_is_branch &&
           ((hist[0].valid && (hist[0].rd == rs || hist[0].rd == rt)) ||
            (hist[1].valid && hist[1].ld && (hist[1].rd == rs || hist[1].rd == rt)));
      e_busy  = (cyc > iss) && (cyc < iss + LAT);
      e_done  = (cyc == iss + LAT - 1);
      mh      = dec_valid && (dec_md_start || dec_md_read) && e_busy;
      e_stall = lu || bh || mh;
      e_flush = e_stall || dec_md_start === 1'bx || flush_decode;
      e_issue = dec_valid && dec_md_start && !e_busy && !lu && !bh && !flush_decode;
      e_fa    = fwd_of(rs);
      e_fb    = fwd_of(rt);
      if (chk_en) begin
         chk("stall_pc",     32'(stall_pc),     32'(e_stall));
         chk("stall_decode", 32'(stall_decode), 32'(e_stall));
         chk("flush_exe",    32'(flush_exe),    32'(e_flush));
         chk("fwd_a",        32'(fwd_a),        32'(e_fa));
         chk("fwd_b",        32'(fwd_b),        32'(e_fb));
         chk("md_issue",     32'(md_issue),     32'(e_issue));
         chk("md_busy",      32'(md_busy),      32'(e_busy));
         chk("md_done",      32'(md_done),      32'(e_done));
`ifdef HAZARD_PERF_CNT_EN
         chk("perf",         perf_stall_cycles, 32'(perf_m));
`endif
      end
   endtask

   task automatic tick();
      wr_t e;
      if (rst) begin
         model_reset();
      end else begin
         e.valid = dec_valid && dec_regwrite && (dec_rd != '0) && !e_stall && !flush_decode;
         e.rd    = int'(dec_rd);
         e.ld    = dec_is_load;
         hist.push_front(e);
         void'(hist.pop_back());
         if (e_issue) iss = cyc;
         if (e_stall) perf_m++;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic bub();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      model_reset();
      @(posedge clk);
      #1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
      chk_en = 1'b1;

      // reset state
      bub();
      chk("rst_md_busy", 32'(md_busy), 32'd0);
      chk("rst_stall",   32'(stall_pc), 32'd0);
      tick();

      // forward from EXE
      drive(1, 1, 2, 3, 1, 0, 0, 0, 0, 0, 0); tick();
      drive(1, 3, 1, 4, 1, 0, 0, 0, 0, 0, 0);
      chk("fwd_exe_a", 32'(fwd_a), 32'd1);
      chk("fwd_exe_stall", 32'(stall_pc), 32'd0);
      tick();

      // forward priority and r0
      drive(1, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0); tick();
      drive(1, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0); tick();
      drive(1, 5, 0, 8, 1, 0, 0, 0, 0, 0, 0);
      chk("fwd_prio_a", 32'(fwd_a), 32'd1);
      chk("fwd_prio_b", 32'(fwd_b), 32'd0);
      tick();
      drive(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0);
      chk("fwd_r0", 32'(fwd_a), 32'd0);
      tick();

      // load-use
      drive(1, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0); tick();
      drive(1, 2, 2, 6, 1, 0, 0, 0, 0, 0, 0);
      chk("lu_stall", 32'(stall_pc), 32'd1);
      chk("lu_flush", 32'(flush_exe), 32'd1);
      tick();
      drive(1, 2, 2, 6, 1, 0, 0, 0, 0, 0, 0);
      chk("lu_after_stall", 32'(stall_pc), 32'd0);
      chk("lu_fwd_a", 32'(fwd_a), 32'd2);
      chk("lu_fwd_b", 32'(fwd_b), 32'd2);
      tick();

      // branch after ALU (1 stall) and after load (2 stalls)
      drive(1, 1, 2, 7, 1, 0, 0, 0, 0, 0, 0); tick();
      drive(1, 7, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      chk("br_alu_stall", 32'(stall_pc), 32'd1); tick();
      drive(1, 7, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      chk("br_alu_go", 32'(stall_pc), 32'd0);
      chk("br_alu_fwd", 32'(fwd_a), 32'd2); tick();
      drive(1, 1, 0, 7, 1, 1, 0, 0, 0, 0, 0); tick();
      drive(1, 7, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      chk("br_ld_stall1", 32'(stall_pc), 32'd1); tick();
      drive(1, 7, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      chk("br_ld_stall2", 32'(stall_pc), 32'd1); tick();
      drive(1, 7, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      chk("br_ld_go", 32'(stall_pc), 32'd0);
      chk("br_ld_fwd", 32'(fwd_a), 32'd3); tick();

      // mul/div: issue at t0, mflo stalls t1..t3, proceeds at t4
      for (int i = 0; i < 3; i++) begin bub(); tick(); end
      drive(1, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0);
      chk("md_issue_t0", 32'(md_issue), 32'd1); tick();
      for (int t = 1; t <= 4; t++) begin
         drive(1, 0, 0, 10, 1, 0, 0, 0, 1, 0, 0);
         chk("md_mflo_stall", 32'(stall_pc), (t < 4) ? 32'd1 : 32'd0);
         chk("md_busy_t",     32'(md_busy),  (t < 4) ? 32'd1 : 32'd0);
         chk("md_done_t",     32'(md_done),  (t == 3) ? 32'd1 : 32'd0);
         tick();
      end

      // reset aborts an operation
      drive(1, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0); tick();
      bub(); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
      bub();
      chk("abort_busy", 32'(md_busy), 32'd0);
      chk("abort_done", 32'(md_done), 32'd0);
      tick();

      // done coincides with a new start: stall once, then issue
      drive(1, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0); tick();
      bub(); tick();
      bub(); tick();
      drive(1, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0);
      chk("b2b_done",  32'(md_done),  32'd1);
      chk("b2b_hold",  32'(md_issue), 32'd0);
      chk("b2b_stall", 32'(stall_pc), 32'd1); tick();
      drive(1, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0);
      chk("b2b_issue", 32'(md_issue), 32'd1); tick();
      for (int i = 0; i < 4; i++) begin bub(); tick(); end

      // flush beats issue and leaves a bubble
      drive(1, 1, 2, 11, 1, 0, 0, 1, 0, 1, 0);
      chk("flush_no_issue", 32'(md_issue), 32'd0);
      chk("flush_exe",      32'(flush_exe), 32'd1); tick();
      drive(1, 11, 0, 12, 1, 0, 0, 0, 0, 0, 0);
      chk("flush_bubble", 32'(fwd_a), 32'd0); tick();

      // random decode traffic
      for (int n = 0; n < 800; n++) begin
         drive(($urandom_range(0, 7) != 0) ? 1 : 0,
               $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
               ($urandom_range(0, 3) != 0) ? 1 : 0,
               ($urandom_range(0, 3) == 0) ? 1 : 0,
               ($urandom_range(0, 5) == 0) ? 1 : 0,
               ($urandom_range(0, 7) == 0) ? 1 : 0,
               ($urandom_range(0, 7) == 0) ? 1 : 0,
               ($urandom_range(0, 9) == 0) ? 1 : 0,
               ($urandom_range(0, 99) == 0) ? 1 : 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
